ah_pl2ddr_sample_collector: RTL and testbench

//  Upstream stage of the PL-to-DDR command FSM. Accepts DATA_WIDTH-bit samples, applies

---
 rtl/ah_pl2ddr_pkg.sv | 27 ++
 rtl/ah_pl2ddr_sample_collector_if.sv | 58 +++++
 rtl/ah_pl2ddr_sample_bram.sv | 47 ++++
 rtl/ah_pl2ddr_sample_collector.sv | 216 +++++++++++++++++++++
 tb/tb_ah_pl2ddr_sample_collector.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ah_pl2ddr_pkg.sv
// ---------------------------------------------------------------------------
// ah_pl2ddr_pkg
//   Shared definitions for the PL-to-DDR sample path: buffer geometry, the
//   collector FSM state encoding and a small pending-lane helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package ah_pl2ddr_pkg;

  localparam int unsigned BRAM_DEPTH = 1024;
  localparam int unsigned BRAM_AW    = 10;
  localparam int unsigned WORD_W     = 32;

  // One slot is kept free so the 10-bit fill level never has to express 1024.
  localparam logic [BRAM_AW-1:0] MAX_COUNT = BRAM_AW'(BRAM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FILL  = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  // Lanes still missing in the current partial word; 0 when word-aligned.
  function automatic logic [5:0] lanes_pending(logic [5:0] lane, int unsigned pack);
    return (lane == 6'd0) ? 6'd0 : (6'(pack) - lane);
  endfunction

endpackage

// File: rtl/ah_pl2ddr_sample_collector_if.sv
// ---------------------------------------------------------------------------
// ah_pl2ddr_sample_collector_if
//   Bundles the control, sample, read and status signals between the
//   PL-to-DDR command FSM / AXI write master (master) and the sample
//   collector (slave).
//   Parameter DATA_WIDTH : sample width, must match the collector instance.
//   master drives all in_* signals and observes all out_* signals;
//   slave is the mirror image.
// ---------------------------------------------------------------------------
interface ah_pl2ddr_sample_collector_if
  import ah_pl2ddr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1
);

  // Control / sample side
  logic                  in_rst_data;
  logic [DATA_WIDTH-1:0] in_sample;
  logic                  in_sample_valid;
  logic                  in_enable_active;
  logic                  in_enable_ovw;
  logic [31:0]           in_undersampling_value;
  logic                  in_data_overwrite;
  logic [DATA_WIDTH-1:0] in_data_overwrite_value;
  logic                  in_fill_data;
  logic                  in_testmode;

  // Drain side
  logic                  in_rd_en;
  logic [WORD_W-1:0]     out_rd_data;

  // Status
  logic [BRAM_AW-1:0]    out_data_available;
  logic [BRAM_AW-1:0]    out_bram_addr_read;
  logic [BRAM_AW-1:0]    out_bram_addr_write;
  logic [31:0]           out_data_index;
  logic [5:0]            out_data_pending;
  logic                  out_data_error;

  modport master (
    output in_rst_data, in_sample, in_sample_valid, in_enable_active,
           in_enable_ovw, in_undersampling_value, in_data_overwrite,
           in_data_overwrite_value, in_fill_data, in_testmode, in_rd_en,
    input  out_rd_data, out_data_available, out_bram_addr_read,
           out_bram_addr_write, out_data_index, out_data_pending,
           out_data_error
  );

  modport slave (
    input  in_rst_data, in_sample, in_sample_valid, in_enable_active,
           in_enable_ovw, in_undersampling_value, in_data_overwrite,
           in_data_overwrite_value, in_fill_data, in_testmode, in_rd_en,
    output out_rd_data, out_data_available, out_bram_addr_read,
           out_bram_addr_write, out_data_index, out_data_pending,
           out_data_error
  );

endinterface

// File: rtl/ah_pl2ddr_sample_bram.sv
// ---------------------------------------------------------------------------
// ah_pl2ddr_sample_bram
//   Simple dual-port BRAM_DEPTH x 32 buffer, one write port and one read
//   port, registered read data (1-cycle latency, holds when not reading).
//   Ports:
//     clk      clock
//     clr      synchronous clear of the read data register only
//     we       write enable
//     waddr    write address
//     wdata    write data
//     re       read enable
//     raddr    read address
//     rd_data  registered read data
// ---------------------------------------------------------------------------
module ah_pl2ddr_sample_bram
  import ah_pl2ddr_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               we,
  input  logic [BRAM_AW-1:0] waddr,
  input  logic [WORD_W-1:0]  wdata,
  input  logic               re,
  input  logic [BRAM_AW-1:0] raddr,
  output logic [WORD_W-1:0]  rd_data
);

  logic [WORD_W-1:0] mem [BRAM_DEPTH];

  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // output register is cleared. Stale contents are never visible because the
  // fill level gates every read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[raddr];
    end
  end

endmodule

// File: rtl/ah_pl2ddr_sample_collector.sv
// ---------------------------------------------------------------------------
// ah_pl2ddr_sample_collector
//   Upstream stage of the PL-to-DDR command FSM. Gates incoming samples by
//   enable / undersampling / overwrite / fill controls, packs them LSB-first
//   into 32-bit words and stores the words in a 1024x32 circular buffer that
//   the AXI write master drains one word per in_rd_en.
//
//   Parameters:
//     DATA_WIDTH   sample width, one of 1,2,4,8,16,32 (PACK = 32/DATA_WIDTH)
//     RESET_VALUE  seed for the packing register on clear (debug aid; the
//                  buffer array itself is never cleared)
//   Ports:
//     clk   clock
//     rst   synchronous, active-high reset
//     bus   ah_pl2ddr_sample_collector_if.slave: control/sample inputs,
//           in_rd_en / out_rd_data drain port, fill level, pointers,
//           accepted-sample index, pending lanes and sticky overflow error
//
//   Optional feature: define AH_PL2DDR_SAMPLE_TESTPATTERN_EN to let
//   in_testmode replace the sample with the low bits of out_data_index.
//   Without it in_testmode is ignored.
// ---------------------------------------------------------------------------
module ah_pl2ddr_sample_collector
  import ah_pl2ddr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 1,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                        clk,
  input  logic                        rst,
  ah_pl2ddr_sample_collector_if.slave bus
);

  localparam int unsigned PACK      = WORD_W / DATA_WIDTH;
  localparam logic [5:0]  LAST_LANE = 6'(PACK - 1);

  // Registered state
  state_e             state_q, state_d;
  logic [5:0]         lane_q, lane_d;
  logic [31:0]        us_cnt_q, us_cnt_d;
  logic [WORD_W-1:0]  pack_q, pack_d;
  logic [BRAM_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [BRAM_AW-1:0] count_q, count_d;
  logic [31:0]        index_q, index_d;
  logic [5:0]         pending_q;
  logic               error_q;

  // Decode
  logic                  clear;
  logic                  strobe;
  logic                  fill_req;
  logic                  accept;
  logic                  keep;
  logic                  lane_wr;
  logic                  word_done;
  logic                  overflow;
  logic                  word_write;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] raw_sample;
  logic [DATA_WIDTH-1:0] kept_value;
  logic [DATA_WIDTH-1:0] lane_value;

  assign clear  = rst | bus.in_rst_data;
  assign strobe = (bus.in_enable_active & bus.in_sample_valid) | bus.in_enable_ovw;

  // A fill request wins over a strobe in the same cycle; the strobe is not
  // seen by the undersampler either.
  assign fill_req = (state_q == ST_RUN) & bus.in_fill_data & (lane_q != 6'd0);
  assign accept   = (state_q == ST_RUN) & strobe & ~fill_req;
  assign keep     = accept & (us_cnt_q == 32'd0);

  // FILL pads one lane per cycle, independent of valid and undersampling.
  assign lane_wr    = keep | (state_q == ST_FILL);
  assign word_done  = lane_wr & (lane_q == LAST_LANE);
  assign overflow   = word_done & (count_q == MAX_COUNT);
  assign word_write = word_done & ~overflow;
  assign rd_fire    = bus.in_rd_en & (count_q != '0);

`ifdef AH_PL2DDR_SAMPLE_TESTPATTERN_EN
  assign raw_sample = bus.in_testmode ? index_q[DATA_WIDTH-1:0] : bus.in_sample;
`else
  logic unused_testmode;
  assign unused_testmode = bus.in_testmode;
  assign raw_sample      = bus.in_sample;
`endif

  assign kept_value = bus.in_data_overwrite ? bus.in_data_overwrite_value : raw_sample;
  assign lane_value = (state_q == ST_FILL) ? bus.in_data_overwrite_value : kept_value;

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (overflow) begin
          state_d = ST_ERROR;
        end else if (fill_req) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (overflow) begin
          state_d = ST_ERROR;
        end else if (word_done) begin
          state_d = ST_RUN;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    lane_d   = lane_q;
    us_cnt_d = us_cnt_q;
    pack_d   = pack_q;
    index_d  = index_q;
    count_d  = count_q;

    if (accept) begin
      us_cnt_d = (us_cnt_q == 32'd0) ? bus.in_undersampling_value : (us_cnt_q - 32'd1);
    end

    if (keep && (index_q != 32'hFFFF_FFFF)) begin
      index_d = index_q + 32'd1;
    end

    if (lane_wr) begin
      for (int i = 0; i < int'(PACK); i++) begin
        if (lane_q == 6'(i)) begin
          pack_d[i*DATA_WIDTH +: DATA_WIDTH] = lane_value;
        end
      end
      // A completed word leaves the pack register either into the buffer or,
      // on overflow, into the void; either way the next sample starts lane 0.
      lane_d = word_done ? 6'd0 : (lane_q + 6'd1);
    end

    unique case ({word_write, rd_fire})
      2'b10:   count_d = count_q + BRAM_AW'(1);
      2'b01:   count_d = count_q - BRAM_AW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      lane_q    <= 6'd0;
      us_cnt_q  <= 32'd0;
      pack_q    <= RESET_VALUE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      index_q   <= 32'd0;
      pending_q <= 6'd0;
      error_q   <= 1'b0;
    end else begin
      lane_q    <= lane_d;
      us_cnt_q  <= us_cnt_d;
      pack_q    <= pack_d;
      count_q   <= count_d;
      index_q   <= index_d;
      pending_q <= lanes_pending(lane_d, PACK);
      if (word_write) begin
        wr_ptr_q <= wr_ptr_q + BRAM_AW'(1);
      end
      if (rd_fire) begin
        rd_ptr_q <= rd_ptr_q + BRAM_AW'(1);
      end
      if (overflow) begin
        error_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Buffer
  // -------------------------------------------------------------------------
  // The full word (including the lane written this cycle) goes straight to
  // the buffer; pack_d rather than pack_q avoids an extra cycle of latency.
  ah_pl2ddr_sample_bram u_bram (
    .clk     (clk),
    .clr     (clear),
    .we      (word_write),
    .waddr   (wr_ptr_q),
    .wdata   (pack_d),
    .re      (rd_fire),
    .raddr   (rd_ptr_q),
    .rd_data (bus.out_rd_data)
  );

  assign bus.out_data_available  = count_q;
  assign bus.out_bram_addr_read  = rd_ptr_q;
  assign bus.out_bram_addr_write = wr_ptr_q;
  assign bus.out_data_index      = index_q;
  assign bus.out_data_pending    = pending_q;
  assign bus.out_data_error      = error_q;

endmodule

// File: tb/tb_ah_pl2ddr_sample_collector.sv
// ---------------------------------------------------------------------------
// tb_ah_pl2ddr_sample_collector
//   Self-checking bench for ah_pl2ddr_sample_collector at DATA_WIDTH=8.
//   A queue-based reference model (word FIFO + list of pending samples)
//   predicts every status output and the popped word each cycle; directed
//   scenarios add fixed expected constants on top.
// ---------------------------------------------------------------------------
module tb_ah_pl2ddr_sample_collector;
  import ah_pl2ddr_pkg::*;

  localparam int DW   = 8;
  localparam int PACK = 32 / DW;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ah_pl2ddr_sample_collector_if #(.DATA_WIDTH(DW)) bus ();

  ah_pl2ddr_sample_collector #(
    .DATA_WIDTH  (DW),
    .RESET_VALUE (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  logic [31:0] m_fifo[$];
  logic [7:0]  m_part[$];
  logic [31:0] m_idx;
  logic [31:0] m_skip;
  bit          m_filling;
  bit          m_err;
  logic [31:0] m_rd;
  int          m_wr_total;
  int          m_rd_total;

  task automatic model_clear();
    m_fifo.delete();
    m_part.delete();
    m_idx      = 0;
    m_skip     = 0;
    m_filling  = 0;
    m_err      = 0;
    m_rd       = 0;
    m_wr_total = 0;
    m_rd_total = 0;
  endtask

  task automatic model_add(input logic [7:0] v, input int size_before);
    logic [31:0] w;
    m_part.push_back(v);
    if (m_part.size() == PACK) begin
      w = 0;
      for (int i = 0; i < PACK; i++) w = w | (32'(m_part[i]) << (8 * i));
      m_part.delete();
      m_filling = 0;
      if (size_before == 1023) m_err = 1;
      else begin
        m_fifo.push_back(w);
        m_wr_total++;
      end
    end
  endtask

  task automatic model_step();
    int          size_before;
    bit          rd;
    logic [7:0]  v;
    if (rst || bus.in_rst_data) begin
      model_clear();
      return;
    end
    size_before = m_fifo.size();
    rd = bus.in_rd_en && (size_before > 0);
    if (!m_err) begin
      if (m_filling) begin
        model_add(bus.in_data_overwrite_value, size_before);
      end else if (bus.in_fill_data && m_part.size() > 0) begin
        m_filling = 1;
      end else if ((bus.in_enable_active && bus.in_sample_valid) || bus.in_enable_ovw) begin
        if (m_skip == 0) begin
          m_skip = bus.in_undersampling_value;
          v = bus.in_sample;
`ifdef AH_PL2DDR_SAMPLE_TESTPATTERN_EN
          if (bus.in_testmode) v = m_idx[7:0];
`endif
          if (bus.in_data_overwrite) v = bus.in_data_overwrite_value;
          if (m_idx != 32'hFFFF_FFFF) m_idx++;
          model_add(v, size_before);
        end else begin
          m_skip--;
        end
      end
    end
    if (rd) begin
      m_rd = m_fifo.pop_front();
      m_rd_total++;
    end
  endtask

  task automatic compare_all();
    int pend;
    pend = (m_part.size() == 0) ? 0 : PACK - m_part.size();
    check("avail",    32'(bus.out_data_available),  32'(m_fifo.size()));
    check("wr_ptr",   32'(bus.out_bram_addr_write), 32'(m_wr_total % 1024));
    check("rd_ptr",   32'(bus.out_bram_addr_read),  32'(m_rd_total % 1024));
    check("index",    bus.out_data_index,           m_idx);
    check("pending",  32'(bus.out_data_pending),    32'(pend));
    check("error",    32'(bus.out_data_error),      32'(m_err));
    check("rd_data",  bus.out_rd_data,              m_rd);
  endtask

  // Inputs change 1 time unit after the edge; outputs are compared there too.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    bus.in_rst_data             = 0;
    bus.in_sample               = '0;
    bus.in_sample_valid         = 0;
    bus.in_enable_active        = 0;
    bus.in_enable_ovw           = 0;
    bus.in_undersampling_value  = 0;
    bus.in_data_overwrite       = 0;
    bus.in_data_overwrite_value = '0;
    bus.in_fill_data            = 0;
    bus.in_testmode             = 0;
    bus.in_rd_en                = 0;
  endtask

  task automatic clear_data();
    bus.in_rst_data = 1;
    tick();
    bus.in_rst_data = 0;
  endtask

  task automatic strobe(input logic [7:0] v);
    bus.in_enable_active = 1;
    bus.in_sample_valid  = 1;
    bus.in_sample        = v;
    tick();
    bus.in_sample_valid  = 0;
  endtask

  task automatic pop();
    bus.in_rd_en = 1;
    tick();
    bus.in_rd_en = 0;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    rst = 1;
    tick();
    tick();
    rst = 0;
    check("reset_avail", 32'(bus.out_data_available), 32'd0);
    check("reset_error", 32'(bus.out_data_error), 32'd0);

    // Eight samples pack into two words.
    clear_data();
    for (int i = 1; i <= 8; i++) strobe(8'(i));
    tick();
    check("t1_avail", 32'(bus.out_data_available), 32'd2);
    pop();
    check("t1_word0", bus.out_rd_data, 32'h0403_0201);
    pop();
    check("t1_word1", bus.out_rd_data, 32'h0807_0605);
    pop();
    check("t1_empty_hold", bus.out_rd_data, 32'h0807_0605);

    // Undersampling keeps one strobe of three.
    clear_data();
    bus.in_undersampling_value = 2;
    for (int i = 1; i <= 12; i++) strobe(8'(i));
    bus.in_undersampling_value = 0;
    check("t2_index",   bus.out_data_index, 32'd4);
    check("t2_pending", 32'(bus.out_data_pending), 32'd0);
    pop();
    check("t2_word", bus.out_rd_data, 32'h0A07_0401);

    // Fill pads a partial word with the overwrite value.
    clear_data();
    for (int i = 1; i <= 3; i++) strobe(8'(i));
    check("t3_pending_before", 32'(bus.out_data_pending), 32'd1);
    bus.in_fill_data            = 1;
    bus.in_data_overwrite_value = 8'hEE;
    tick();
    bus.in_fill_data = 0;
    check("t3_pending_fill", 32'(bus.out_data_pending), 32'd1);
    tick();
    check("t3_pending_after", 32'(bus.out_data_pending), 32'd0);
    check("t3_index", bus.out_data_index, 32'd3);
    pop();
    check("t3_word", bus.out_rd_data, 32'hEE03_0201);
    bus.in_data_overwrite_value = '0;

    // Read and write in the same cycle keep the fill level.
    clear_data();
    for (int i = 0; i < 23; i++) strobe(8'(8'h10 + i));
    check("t5_avail_before", 32'(bus.out_data_available), 32'd5);
    bus.in_rd_en = 1;
    strobe(8'h27);
    bus.in_rd_en = 0;
    check("t5_avail_after", 32'(bus.out_data_available), 32'd5);
    check("t5_rd_oldest", bus.out_rd_data, 32'h1312_1110);

    // Overflow: 1023 words fit, the next word sets the sticky error.
    clear_data();
    bus.in_enable_ovw = 1;
    for (int i = 0; i < 4092; i++) begin
      bus.in_sample = 8'(i);
      tick();
    end
    check("t4_full", 32'(bus.out_data_available), 32'd1023);
    for (int i = 4092; i < 4096; i++) begin
      bus.in_sample = 8'(i);
      tick();
    end
    check("t4_error", 32'(bus.out_data_error), 32'd1);
    check("t4_avail", 32'(bus.out_data_available), 32'd1023);
    for (int i = 0; i < 8; i++) tick();
    check("t4_index_frozen", bus.out_data_index, 32'd4096);
    bus.in_enable_ovw = 0;
    pop();
    check("t4_read_in_error", bus.out_rd_data, 32'h0302_0100);
    check("t4_avail_read", 32'(bus.out_data_available), 32'd1022);
    clear_data();
    check("t4_cleared_err", 32'(bus.out_data_error), 32'd0);
    check("t4_cleared_avail", 32'(bus.out_data_available), 32'd0);

    // Streaming write+read to wrap both pointers past 1023.
    bus.in_enable_ovw = 1;
    bus.in_rd_en      = 1;
    for (int i = 0; i < 4 * 1030; i++) begin
      bus.in_sample = 8'($urandom);
      tick();
    end
    bus.in_enable_ovw = 0;
    tick();
    bus.in_rd_en = 0;
    check("wrap_wr_ptr", 32'(bus.out_bram_addr_write), 32'd6);
    check("wrap_rd_ptr", 32'(bus.out_bram_addr_read), 32'd6);

`ifdef AH_PL2DDR_SAMPLE_TESTPATTERN_EN
    clear_data();
    bus.in_testmode   = 1;
    bus.in_enable_ovw = 1;
    for (int i = 0; i < 4; i++) tick();
    bus.in_enable_ovw = 0;
    bus.in_testmode   = 0;
    pop();
    check("tp_word", bus.out_rd_data, 32'h0302_0100);
`endif

    // Randomized traffic against the model.
    clear_data();
    for (int c = 0; c < 3000; c++) begin
      bus.in_rst_data             = ($urandom_range(199) == 0);
      bus.in_sample               = 8'($urandom);
      bus.in_sample_valid         = ($urandom_range(99) < 50);
      bus.in_enable_active        = ($urandom_range(99) < 80);
      bus.in_enable_ovw           = ($urandom_range(99) < 10);
      bus.in_data_overwrite       = ($urandom_range(99) < 20);
      bus.in_data_overwrite_value = 8'($urandom);
      bus.in_fill_data            = ($urandom_range(99) < 5);
      bus.in_testmode             = ($urandom_range(99) < 20);
      bus.in_rd_en                = ($urandom_range(99) < 40);
      if ($urandom_range(49) == 0) bus.in_undersampling_value = $urandom_range(3);
      tick();
    end
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
